// File: rtl/mem_arbiter.sv
// Two-client (fetch / load-store) arbiter in front of the SRAM controller; one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives the data port fixed priority.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [1:0]    m_size,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_valid
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {NONE, FETCH, DATA} grant_t;

    state_t        state_q, state_d;
    grant_t        grant_q, grant_d;
    logic          m_req_q, m_req_d;
    logic          m_rw_q, m_rw_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [1:0]    m_size_q, m_size_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_data;

`ifdef MEM_ARB_RR_EN
    grant_t        last_grant_q, last_grant_d;

    // On contention the client that did not win last time is served.
    always_comb begin
        pick_data = d_req && (!i_req || (last_grant_q == FETCH));
    end
`else
    always_comb begin
        pick_data = d_req;
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        m_req_d   = 1'b0;
        m_rw_d    = m_rw_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_size_d  = m_size_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    m_req_d = 1'b1;
                    state_d = WAIT;
                    if (pick_data) begin
                        grant_d   = DATA;
                        m_rw_d    = d_rw;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_size_d  = d_size;
                    end else begin
                        grant_d  = FETCH;
                        m_rw_d   = 1'b0;
                        m_addr_d = i_addr;
                        m_size_d = 2'h2;
                    end
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_d;
`endif
                end
            end
            WAIT: begin
                // Request fields stay frozen here; the controller reads rw/write_data after acceptance.
                if (m_valid) begin
                    state_d = RESP;
                    if (grant_q == DATA) begin
                        d_rdata_d = m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ack_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= NONE;
            m_req_q   <= 1'b0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_size_q  <= 2'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= FETCH;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_req_q   <= m_req_d;
            m_rw_q    <= m_rw_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_size_q  <= m_size_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign m_req   = m_req_q;
    assign m_rw    = m_rw_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_size  = m_size_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: acts as both clients and as the memory controller,
// predicting every grant, field and ack from a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_rw = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [1:0]    d_size = 2'h0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_size;
    logic [DW-1:0] m_rdata = '0;
    logic          m_valid = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_rdata(m_rdata), .m_valid(m_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int vcyc = 0;
    bit abort = 1'b0;

    // Client-side view: what each client is currently asking for.
    bit          ip, dp;
    logic [31:0] ia, da, dwd;
    logic        dr;
    logic [1:0]  ds;

    // Expected memory-port fields and returned data.
    bit          last_data;
    logic        exp_rw;
    logic [31:0] exp_addr, exp_wdata, exp_irdata;
    logic [1:0]  exp_size;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Arbitration rule: data wins, except that round-robin alternates on contention.
    function automatic bit pickData(input bit f, input bit d, input bit last_d);
`ifdef MEM_ARB_RR_EN
        if (f && d) return !last_d;
`endif
        return d;
    endfunction

    task automatic newFetch;
        ip = 1'b1;
        ia = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic newData;
        dp  = 1'b1;
        da  = $urandom;
        dwd = $urandom;
        dr  = 1'($urandom_range(0, 1));
        ds  = 2'($urandom_range(0, 2));
    endtask

    // Raise fresh requests on idle clients (both may rise together) and drive the ports.
    task automatic applyStimulus;
        int sel;
        if (!ip && !dp) begin
            sel = $urandom_range(0, 2);
            if (sel != 1) newFetch();
            if (sel != 0) newData();
        end else if ($urandom_range(0, 1) == 1) begin
            if (!ip) newFetch();
            if (!dp) newData();
        end
        i_req   = ip;
        i_addr  = ia;
        d_req   = dp;
        d_rw    = dr;
        d_addr  = da;
        d_wdata = dwd;
        d_size  = ds;
    endtask

    task automatic checkFields(input string phase);
        checkOutput({phase, "_m_rw"}, m_rw, exp_rw);
        checkOutput({phase, "_m_addr"}, m_addr, exp_addr);
        checkOutput({phase, "_m_wdata"}, m_wdata, exp_wdata);
        checkOutput({phase, "_m_size"}, m_size, exp_size);
    endtask

    task automatic waitIssue(output bit ok);
        int n;
        n = 0;
        while (m_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (m_req === 1'b1);
        if (!ok) begin
            checkOutput("m_req_timeout", m_req, 1);
            abort = 1'b1;
        end
    endtask

    task automatic runTransaction(input bit chk_gap);
        bit          win_d, ok;
        int          lat;
        logic [31:0] rdat;
        applyStimulus();
        win_d = pickData(ip, dp, last_data);
        waitIssue(ok);
        if (!ok) return;
        if (chk_gap) checkOutput("issue_gap", cyc - vcyc, 3);
        if (win_d) begin
            exp_rw = dr; exp_addr = da; exp_wdata = dwd; exp_size = ds;
        end else begin
            exp_rw = 1'b0; exp_addr = ia; exp_size = 2'h2;
        end
        last_data = win_d;
        checkFields("issue");
        lat = $urandom_range(0, 4);
        repeat (lat) begin
            tick();
            checkOutput("m_req_pulse", m_req, 0);
            checkFields("hold");
            checkOutput("ack_early", {i_ack, d_ack}, 0);
        end
        rdat    = $urandom;
        m_rdata = rdat;
        m_valid = 1'b1;
        vcyc    = cyc;
        tick();
        m_valid = 1'b0;
        m_rdata = $urandom;
        checkOutput("i_ack", i_ack, !win_d);
        checkOutput("d_ack", d_ack, win_d);
        checkOutput("m_req_after_valid", m_req, 0);
        if (win_d) begin
            if (!dr) checkOutput("d_rdata", d_rdata, rdat);
            dp = 1'b0;
            d_req = 1'b0;
        end else begin
            exp_irdata = rdat;
            checkOutput("i_rdata", i_rdata, exp_irdata);
            ip = 1'b0;
            i_req = 1'b0;
        end
        // A stray m_valid while the arbiter is responding must be ignored.
        if ($urandom_range(0, 3) == 0) m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        checkOutput("ack_pulse", {i_ack, d_ack}, 0);
        checkOutput("m_req_resp", m_req, 0);
        checkOutput("i_rdata_hold", i_rdata, exp_irdata);
    endtask

    task automatic checkResetOutputs(input string phase);
        checkOutput({phase, "_m_req"}, m_req, 0);
        checkOutput({phase, "_m_rw"}, m_rw, 0);
        checkOutput({phase, "_m_addr"}, m_addr, 0);
        checkOutput({phase, "_m_wdata"}, m_wdata, 0);
        checkOutput({phase, "_m_size"}, m_size, 0);
        checkOutput({phase, "_acks"}, {i_ack, d_ack}, 0);
        checkOutput({phase, "_i_rdata"}, i_rdata, 0);
        checkOutput({phase, "_d_rdata"}, d_rdata, 0);
    endtask

    task automatic modelReset;
        ip = 1'b0; dp = 1'b0;
        last_data = 1'b0;
        exp_wdata = '0;
        exp_irdata = '0;
    endtask

    initial begin
        bit ok;
        modelReset();
        repeat (3) tick();
        checkResetOutputs("reset");
        reset = 1'b1;

        for (int t = 0; t < 40 && !abort; t++) runTransaction(t != 0);

        // Reset while a fetch is outstanding, then a late m_valid must not produce an ack.
        if (!abort) begin
            i_req  = 1'b1;
            i_addr = 32'h0000_0040;
            waitIssue(ok);
            if (ok) begin
                tick();
                reset = 1'b0;
                tick();
                checkResetOutputs("mid_reset");
                i_req = 1'b0;
                d_req = 1'b0;
                modelReset();
                reset = 1'b1;
                m_valid = 1'b1;
                m_rdata = 32'hDEAD_BEEF;
                tick();
                m_valid = 1'b0;
                tick();
                checkOutput("late_valid_acks", {i_ack, d_ack}, 0);
                checkOutput("late_valid_m_req", m_req, 0);
                checkOutput("late_valid_i_rdata", i_rdata, 0);
            end
        end

        for (int t = 0; t < 20 && !abort; t++) runTransaction(t != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
